p88_load_ctrl: RTL and testbench

- Sequences a P88 program download from the ioctl stream into console memory while holding the CPU/SlipStream in reset.
- Parses C8 (data section) and CA (entry point) records.
- Writes section bytes to DRAM and a far-JMP reset vector (EA offL offH segL segH) to boot ROM through a single req/ack memory write port.
- The top level muxes this port onto the RAM address/data/write lines while load_reset is high.

---
 rtl/p88_load_ctrl.sv | 191 +++++++++++++++++++
 tb/tb_p88_load_ctrl.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/p88_load_ctrl.sv
// p88_load_ctrl: parses a P88 ioctl download into DRAM section writes and a ROM far-JMP reset vector
module p88_load_ctrl #(
  parameter int ADDR_W     = 20,
  parameter int ROM_ADDR_W = 3
) (
  input  logic              clk_sys,
  input  logic              resetL,
  input  logic              ioctl_download,
  input  logic              ioctl_wr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  output logic              load_reset,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_data,
  output logic              mem_req,
  input  logic              mem_ack,
  output logic              mem_sel_rom,
  output logic              vector_valid,
  output logic              error,
  output logic [7:0]        sections
);
  typedef enum logic [2:0] {IDLE, CMD, HDR_C8, DATA, DATA_WR, HDR_CA, VEC, ERR} state_t;
  state_t state, state_n;
  logic dl_q, rise, fall, take;
  logic [2:0] idx, idx_n;
  logic [15:0] seg, seg_n, off, off_n, len, len_n;
  logic [ADDR_W-1:0] addr_n;
  logic [7:0] data_n, sec_n, sec_inc, vec_byte;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic req_n, rom_n, wait_n, lr_n, vv_n, err_n;
  assign rise     = ioctl_download & ~dl_q;
  assign fall     = ~ioctl_download & dl_q;
  assign take     = ioctl_wr & ~ioctl_wait;
  assign sec_inc  = (sections == 8'hFF) ? sections : sections + 8'd1;
  assign rom_addr = ROM_ADDR_W'(idx);
  assign vec_byte = (idx == 3'd0) ? 8'hEA :
                    (idx == 3'd1) ? off[7:0] :
                    (idx == 3'd2) ? off[15:8] :
                    (idx == 3'd3) ? seg[7:0] : seg[15:8];
  // state and datapath registers; everything clears on reset
  always_ff @(posedge clk_sys or negedge resetL) begin
    if (!resetL) begin
      state        <= IDLE;
      dl_q         <= 1'b0;
      idx          <= '0;
      seg          <= '0;
      off          <= '0;
      len          <= '0;
      mem_addr     <= '0;
      mem_data     <= '0;
      mem_req      <= 1'b0;
      mem_sel_rom  <= 1'b0;
      ioctl_wait   <= 1'b0;
      load_reset   <= 1'b0;
      vector_valid <= 1'b0;
      error        <= 1'b0;
      sections     <= '0;
    end else begin
      state        <= state_n;
      dl_q         <= ioctl_download;
      idx          <= idx_n;
      seg          <= seg_n;
      off          <= off_n;
      len          <= len_n;
      mem_addr     <= addr_n;
      mem_data     <= data_n;
      mem_req      <= req_n;
      mem_sel_rom  <= rom_n;
      ioctl_wait   <= wait_n;
      load_reset   <= lr_n;
      vector_valid <= vv_n;
      error        <= err_n;
      sections     <= sec_n;
    end
  end
  // record parser: download edges override everything, otherwise step the current record
  always_comb begin
    state_n = state;
    idx_n   = idx;
    seg_n   = seg;
    off_n   = off;
    len_n   = len;
    addr_n  = mem_addr;
    data_n  = mem_data;
    req_n   = mem_req;
    rom_n   = mem_sel_rom;
    wait_n  = ioctl_wait;
    lr_n    = load_reset;
    vv_n    = vector_valid;
    err_n   = error;
    sec_n   = sections;
    if (fall) begin
      state_n = IDLE;
      lr_n    = 1'b0;
      req_n   = 1'b0;
      wait_n  = 1'b0;
    end else if (rise) begin
      state_n = CMD;
      lr_n    = 1'b1;
      req_n   = 1'b0;
      wait_n  = 1'b0;
      vv_n    = 1'b0;
      err_n   = 1'b0;
      sec_n   = '0;
    end else begin
      case (state)
        CMD: begin
          wait_n = 1'b0;
          if (take) begin
            idx_n = '0;
            if (ioctl_dout == 8'hC8) state_n = HDR_C8;
            else if (ioctl_dout == 8'hCA) state_n = HDR_CA;
            else begin
              state_n = ERR;
              err_n   = 1'b1;
            end
          end
        end
        HDR_C8: if (take) begin
          idx_n = idx + 3'd1;
          case (idx)
            3'd0: seg_n[7:0]  = ioctl_dout;
            3'd1: seg_n[15:8] = ioctl_dout;
            3'd2: off_n[7:0]  = ioctl_dout;
            3'd3: off_n[15:8] = ioctl_dout;
            3'd6: len_n[7:0]  = ioctl_dout;
            3'd7: begin
              len_n[15:8] = ioctl_dout;
              addr_n      = ADDR_W'({seg, 4'd0}) + ADDR_W'(off);
              if ({ioctl_dout, len[7:0]} == 16'd0) begin
                sec_n   = sec_inc;
                state_n = CMD;
              end else state_n = DATA;
            end
            default: ;
          endcase
        end
        DATA: begin
          wait_n = 1'b0;
          if (take) begin
            data_n  = ioctl_dout;
            req_n   = 1'b1;
            rom_n   = 1'b0;
            wait_n  = 1'b1;
            state_n = DATA_WR;
          end
        end
        DATA_WR: if (mem_req && mem_ack) begin
          req_n  = 1'b0;
          addr_n = mem_addr + ADDR_W'(1);
          len_n  = len - 16'd1;
          if (len == 16'd1) begin
            sec_n   = sec_inc;
            state_n = CMD;
          end else state_n = DATA;
        end
        HDR_CA: if (take) begin
          idx_n = idx + 3'd1;
          case (idx)
            3'd0: seg_n[7:0]  = ioctl_dout;
            3'd1: seg_n[15:8] = ioctl_dout;
            3'd2: off_n[7:0]  = ioctl_dout;
            default: begin
              off_n[15:8] = ioctl_dout;
              wait_n      = 1'b1;
              idx_n       = '0;
              state_n     = VEC;
            end
          endcase
        end
        VEC: begin
          if (!mem_req) begin
            req_n  = 1'b1;
            rom_n  = 1'b1;
            addr_n = ADDR_W'(rom_addr);
            data_n = vec_byte;
          end else if (mem_ack) begin
            req_n = 1'b0;
            idx_n = idx + 3'd1;
            if (idx == 3'd4) begin
              wait_n  = 1'b0;
              vv_n    = 1'b1;
              state_n = CMD;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_p88_load_ctrl.sv
// tb_p88_load_ctrl: directed vectors and record sequences for the P88 loader
module tb_p88_load_ctrl;
  typedef struct {
    logic dl, wr; logic [7:0] d; logic ak;
    logic wt, lr, rq; logic [19:0] a; logic [7:0] dt, sec;
  } vec_t;
  typedef struct { logic rom; logic [19:0] addr; logic [7:0] data; } wr_t;
  logic clk_sys = 0, resetL = 1, ioctl_download = 0, ioctl_wr = 0;
  logic [7:0] ioctl_dout = 0;
  logic tbl_ack = 0, resp_ack = 0, ack_en = 0, mem_ack;
  logic ioctl_wait, load_reset, mem_req, mem_sel_rom, vector_valid, error;
  logic [19:0] mem_addr;
  logic [7:0] mem_data, sections;
  int ack_dly = 1, errors = 0, checks = 0;
  wr_t wlog[$];
  vec_t tv[19];
  assign mem_ack = ack_en ? resp_ack : tbl_ack;
  p88_load_ctrl #(.ADDR_W(20), .ROM_ADDR_W(3)) dut (
    .clk_sys(clk_sys), .resetL(resetL), .ioctl_download(ioctl_download),
    .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait),
    .load_reset(load_reset), .mem_addr(mem_addr), .mem_data(mem_data),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_sel_rom(mem_sel_rom),
    .vector_valid(vector_valid), .error(error), .sections(sections)
  );
  always #5 clk_sys = ~clk_sys;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk_sys);
    #1;
  endtask
  function automatic vec_t v(input logic dl, wr, input logic [7:0] d, input logic ak, wt, lr, rq,
                             input logic [19:0] a, input logic [7:0] dt, sec);
    vec_t r;
    r.dl = dl; r.wr = wr; r.d = d; r.ak = ak; r.wt = wt; r.lr = lr; r.rq = rq;
    r.a = a; r.dt = dt; r.sec = sec;
    return r;
  endfunction
  // memory responder: acks each request after ack_dly cycles and logs it
  initial begin
    int cnt = 0;
    logic [28:0] cap = 0;
    forever begin
      tick;
      if (resp_ack) resp_ack = 0;
      else if (ack_en && mem_req) begin
        if (cnt == 0) cap = {mem_sel_rom, mem_addr, mem_data};
        cnt++;
        if (cnt >= ack_dly) begin
          chk("req_stable", {3'd0, mem_sel_rom, mem_addr, mem_data}, {3'd0, cap});
          wlog.push_back('{mem_sel_rom, mem_addr, mem_data});
          resp_ack = 1;
          cnt = 0;
        end
      end else cnt = 0;
    end
  end
  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    while (ioctl_wait && n < 200) begin
      tick;
      n++;
    end
    if (ioctl_wait) chk("wait_timeout", 1, 0);
    ioctl_wr = 1;
    ioctl_dout = b;
    tick;
    ioctl_wr = 0;
  endtask
  task automatic send_c8(input logic [15:0] s, input logic [15:0] o, input logic [15:0] l);
    send_byte(8'hC8); send_byte(s[7:0]); send_byte(s[15:8]); send_byte(o[7:0]);
    send_byte(o[15:8]); send_byte(8'h00); send_byte(8'h00); send_byte(l[7:0]); send_byte(l[15:8]);
  endtask
  task automatic wait_quiet;
    int n = 0;
    while ((mem_req || ioctl_wait) && n < 200) begin
      tick;
      n++;
    end
    chk("quiet_timeout", {30'd0, mem_req, ioctl_wait}, 0);
  endtask
  task automatic check_wr(input int i, input logic rom, input logic [19:0] a, input logic [7:0] d);
    if (i >= wlog.size()) chk($sformatf("wr%0d_missing", i), wlog.size(), i + 1);
    else begin
      chk($sformatf("wr%0d_rom", i), wlog[i].rom, rom);
      chk($sformatf("wr%0d_addr", i), wlog[i].addr, a);
      chk($sformatf("wr%0d_data", i), wlog[i].data, d);
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int base, bad;
    tv[0]  = v(1, 0, 8'h00, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[1]  = v(1, 1, 8'hC8, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[2]  = v(1, 1, 8'h00, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[3]  = v(1, 1, 8'h10, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[4]  = v(1, 1, 8'h10, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[5]  = v(1, 1, 8'h00, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[6]  = v(1, 1, 8'h00, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[7]  = v(1, 1, 8'h00, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[8]  = v(1, 1, 8'h03, 0, 0, 1, 0, 20'h00000, 8'h00, 0);
    tv[9]  = v(1, 1, 8'h00, 0, 0, 1, 0, 20'h10010, 8'h00, 0);
    tv[10] = v(1, 1, 8'hAA, 0, 1, 1, 1, 20'h10010, 8'hAA, 0);
    tv[11] = v(1, 1, 8'hDD, 1, 1, 1, 0, 20'h10011, 8'hAA, 0);
    tv[12] = v(1, 0, 8'h00, 0, 0, 1, 0, 20'h10011, 8'hAA, 0);
    tv[13] = v(1, 1, 8'hBB, 0, 1, 1, 1, 20'h10011, 8'hBB, 0);
    tv[14] = v(1, 0, 8'h00, 1, 1, 1, 0, 20'h10012, 8'hBB, 0);
    tv[15] = v(1, 0, 8'h00, 0, 0, 1, 0, 20'h10012, 8'hBB, 0);
    tv[16] = v(1, 1, 8'hCC, 0, 1, 1, 1, 20'h10012, 8'hCC, 0);
    tv[17] = v(1, 0, 8'h00, 1, 1, 1, 0, 20'h10013, 8'hCC, 1);
    tv[18] = v(1, 0, 8'h00, 0, 0, 1, 0, 20'h10013, 8'hCC, 1);
    #1 resetL = 0;
    #2;
    chk("rst_outputs", {ioctl_wait, load_reset, mem_req, mem_sel_rom, vector_valid, error}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_data_sec", {mem_data, sections}, 0);
    tick;
    resetL = 1;
    tick;
    for (int i = 0; i < 19; i++) begin
      ioctl_download = tv[i].dl;
      ioctl_wr = tv[i].wr;
      ioctl_dout = tv[i].d;
      tbl_ack = tv[i].ak;
      tick;
      chk($sformatf("tv%0d_wait", i), ioctl_wait, tv[i].wt);
      chk($sformatf("tv%0d_load_reset", i), load_reset, tv[i].lr);
      chk($sformatf("tv%0d_req", i), mem_req, tv[i].rq);
      chk($sformatf("tv%0d_rom", i), mem_sel_rom, 0);
      chk($sformatf("tv%0d_addr", i), mem_addr, tv[i].a);
      chk($sformatf("tv%0d_data", i), mem_data, tv[i].dt);
      chk($sformatf("tv%0d_sections", i), sections, tv[i].sec);
    end
    ioctl_wr = 0;
    tbl_ack = 0;
    ack_en = 1;
    base = wlog.size();
    send_c8(16'hFFFF, 16'h0020, 16'd2);
    send_byte(8'h11);
    send_byte(8'h22);
    wait_quiet;
    check_wr(base, 0, 20'h00010, 8'h11);
    check_wr(base + 1, 0, 20'h00011, 8'h22);
    chk("wrap_sections", sections, 2);
    base = wlog.size();
    send_c8(16'h0300, 16'h0000, 16'd0);
    repeat (3) tick;
    chk("len0_no_writes", wlog.size(), base);
    chk("len0_sections", sections, 3);
    base = wlog.size();
    send_byte(8'hCA); send_byte(8'h00); send_byte(8'h20); send_byte(8'h00); send_byte(8'h01);
    chk("ca_wait_after_hdr", ioctl_wait, 1);
    bad = 0;
    for (int n = 0; n < 60 && !vector_valid; n++) begin
      tick;
      if (!vector_valid && !ioctl_wait) bad = 1;
    end
    chk("ca_wait_held", bad, 0);
    chk("ca_vector_valid", vector_valid, 1);
    tick;
    chk("ca_wait_released", ioctl_wait, 0);
    check_wr(base, 1, 20'h0, 8'hEA);
    check_wr(base + 1, 1, 20'h1, 8'h00);
    check_wr(base + 2, 1, 20'h2, 8'h01);
    check_wr(base + 3, 1, 20'h3, 8'h00);
    check_wr(base + 4, 1, 20'h4, 8'h20);
    chk("ca_sections", sections, 3);
    ack_dly = 10;
    base = wlog.size();
    send_c8(16'h0000, 16'h0100, 16'd2);
    send_byte(8'h5A);
    ioctl_wr = 1;
    ioctl_dout = 8'hFF;
    bad = 0;
    repeat (8) begin
      tick;
      if (!(mem_req && ioctl_wait && mem_addr == 20'h00100 && mem_data == 8'h5A)) bad = 1;
    end
    ioctl_wr = 0;
    chk("stall_hold_steady", bad, 0);
    send_byte(8'hA5);
    wait_quiet;
    chk("stall_write_count", wlog.size(), base + 2);
    check_wr(base, 0, 20'h00100, 8'h5A);
    check_wr(base + 1, 0, 20'h00101, 8'hA5);
    chk("stall_sections", sections, 4);
    ack_dly = 1;
    send_byte(8'h55);
    chk("err_set", error, 1);
    base = wlog.size();
    send_byte(8'hC8); send_byte(8'h00); send_byte(8'hCA); send_byte(8'h01);
    repeat (3) tick;
    chk("err_no_writes", wlog.size(), base);
    chk("err_wait_low", ioctl_wait, 0);
    ioctl_download = 0;
    tick;
    chk("err_end_load_reset", load_reset, 0);
    chk("err_end_error_held", error, 1);
    chk("err_end_vv_held", vector_valid, 1);
    chk("err_end_sections_held", sections, 4);
    ack_en = 0;
    ioctl_download = 1;
    tick;
    chk("dl2_load_reset", load_reset, 1);
    chk("dl2_cleared", {vector_valid, error, sections}, 0);
    send_c8(16'h0001, 16'h0002, 16'd1);
    send_byte(8'h77);
    chk("rstw_req", mem_req, 1);
    chk("rstw_addr", mem_addr, 20'h00012);
    chk("rstw_data", mem_data, 8'h77);
    resetL = 0;
    #1;
    chk("rstw_async_clear", {mem_req, ioctl_wait, load_reset}, 0);
    chk("rstw_addr_clear", mem_addr, 0);
    ioctl_download = 0;
    tick;
    resetL = 1;
    tick;
    ioctl_download = 1;
    tick;
    send_c8(16'h0000, 16'h0040, 16'd2);
    send_byte(8'h88);
    chk("abort_req", mem_req, 1);
    ioctl_download = 0;
    tick;
    chk("abort_clear", {mem_req, ioctl_wait, load_reset}, 0);
    chk("abort_addr", mem_addr, 20'h00040);
    tbl_ack = 1;
    tick;
    tbl_ack = 0;
    chk("late_ack_req", mem_req, 0);
    chk("late_ack_addr", mem_addr, 20'h00040);
    chk("late_ack_sections", sections, 0);
    ioctl_wr = 1;
    ioctl_dout = 8'hC8;
    tick;
    ioctl_wr = 0;
    tick;
    chk("idle_ignores", {mem_req, ioctl_wait, load_reset, error}, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
